// File: rtl/mmu_pkg.sv
// Shared types for the TLB search-port arbiter: exception codes, arbiter
// states, requester identity, and the physical-address assembly helper.
package mmu_pkg;

   localparam int unsigned PAGE_OFS_W = 12;  // 4 KB pages only

   typedef enum logic [2:0] {
      ECODE_NONE = 3'd0,
      ECODE_TLBR = 3'd1,
      ECODE_PIL  = 3'd2,
      ECODE_PIS  = 3'd3,
      ECODE_PIF  = 3'd4,
      ECODE_PME  = 3'd5,
      ECODE_PPI  = 3'd6
   } ecode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_LS = 1'b1
   } req_id_t;

   function automatic logic [31:0] make_paddr(input logic [19:0] ppn,
                                              input logic [PAGE_OFS_W-1:0] ofs);
      return {ppn, ofs};
   endfunction

endpackage

// File: rtl/tlb_port_arbiter_if.sv
// Bundle of request, TLB search and response signals around the arbiter.
// master = pipeline front ends + TLB side, slave = the arbiter itself.
interface tlb_port_arbiter_if;
   import mmu_pkg::*;

   logic        flush;
   logic [1:0]  csr_plv;

   logic        if_req_valid;
   logic        if_req_ready;
   logic [31:0] if_vaddr;

   logic        ls_req_valid;
   logic        ls_req_ready;
   logic [31:0] ls_vaddr;
   logic        ls_is_store;

   logic        tlb_s_valid;
   logic [18:0] tlb_s_vppn;
   logic        tlb_s_va_bit12;
   logic        tlb_s_found;
   logic [19:0] tlb_s_ppn;
   logic        tlb_s_v;
   logic        tlb_s_d;
   logic [1:0]  tlb_s_plv;

   logic        if_resp_valid;
   logic        if_resp_ready;
   logic        ls_resp_valid;
   logic        ls_resp_ready;
   logic [31:0] resp_paddr;
   ecode_t      resp_ecode;

   modport master (
      output flush, csr_plv,
      output if_req_valid, if_vaddr,
      output ls_req_valid, ls_vaddr, ls_is_store,
      output tlb_s_found, tlb_s_ppn, tlb_s_v, tlb_s_d, tlb_s_plv,
      output if_resp_ready, ls_resp_ready,
      input  if_req_ready, ls_req_ready,
      input  tlb_s_valid, tlb_s_vppn, tlb_s_va_bit12,
      input  if_resp_valid, ls_resp_valid, resp_paddr, resp_ecode
   );

   modport slave (
      input  flush, csr_plv,
      input  if_req_valid, if_vaddr,
      input  ls_req_valid, ls_vaddr, ls_is_store,
      input  tlb_s_found, tlb_s_ppn, tlb_s_v, tlb_s_d, tlb_s_plv,
      input  if_resp_ready, ls_resp_ready,
      output if_req_ready, ls_req_ready,
      output tlb_s_valid, tlb_s_vppn, tlb_s_va_bit12,
      output if_resp_valid, ls_resp_valid, resp_paddr, resp_ecode
   );

endinterface

// File: rtl/tlb_perm_check.sv
// Combinational permission check on a TLB search result. The first failing
// check in priority order determines the exception code.
module tlb_perm_check
   import mmu_pkg::*;
(
   input  logic       found_i,
   input  logic       v_i,
   input  logic       d_i,
   input  logic [1:0] plv_i,
   input  logic [1:0] csr_plv_i,
   input  req_id_t    req_i,
   input  logic       store_i,
   output ecode_t     ecode_o
);

   // Priority: miss, invalid page, privilege, clean page written by a store.
   always_comb begin
      ecode_o = ECODE_NONE;
      if (!found_i) begin
         ecode_o = ECODE_TLBR;
      end else if (!v_i) begin
         if (req_i == REQ_IF)  ecode_o = ECODE_PIF;
         else if (store_i)     ecode_o = ECODE_PIS;
         else                  ecode_o = ECODE_PIL;
      end else if (csr_plv_i > plv_i) begin
         ecode_o = ECODE_PPI;
      end else if ((req_i == REQ_LS) && store_i && !d_i) begin
         ecode_o = ECODE_PME;
      end
   end

endmodule

// File: rtl/tlb_port_arbiter.sv
// Shares one TLB search port between IF and LS. LS normally wins; a pending
// IF request that has lost STARVE_LIMIT consecutive arbitrations is forced
// through. One translation is in flight at a time: IDLE -> LOOKUP -> RESP.
module tlb_port_arbiter
   import mmu_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
)
(
   input logic               clk,
   input logic               reset,
   tlb_port_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t            state_q, state_d;
   logic [CNT_W-1:0]      starve_q, starve_d;
   logic [PAGE_OFS_W-1:0] ofs_q, ofs_d;
   req_id_t               id_q, id_d;
   logic                  store_q, store_d;
   logic [31:0]           paddr_q, paddr_d;
   ecode_t                ecode_q, ecode_d;

   logic        force_if;
   logic        grant_ls;
   logic        grant_if;
   logic        accept;
   logic        resp_hs;
   logic [31:0] win_vaddr;
   ecode_t      chk_ecode;

   tlb_perm_check u_perm (
      .found_i   (bus.tlb_s_found),
      .v_i       (bus.tlb_s_v),
      .d_i       (bus.tlb_s_d),
      .plv_i     (bus.tlb_s_plv),
      .csr_plv_i (bus.csr_plv),
      .req_i     (id_q),
      .store_i   (store_q),
      .ecode_o   (chk_ecode)
   );

   // Arbitration: LS priority unless IF has hit the starvation limit.
   always_comb begin
      force_if  = (starve_q == CNT_MAX) && bus.if_req_valid;
      grant_ls  = bus.ls_req_valid && !force_if;
      grant_if  = bus.if_req_valid && !grant_ls;
      accept    = (state_q == ST_IDLE) && !bus.flush && !reset && (grant_ls || grant_if);
      win_vaddr = grant_ls ? bus.ls_vaddr : bus.if_vaddr;
      resp_hs   = (id_q == REQ_IF) ? bus.if_resp_ready : bus.ls_resp_ready;
   end

   // Handshake, search strobe and response outputs.
   always_comb begin
      bus.if_req_ready   = accept && grant_if;
      bus.ls_req_ready   = accept && grant_ls;
      bus.tlb_s_valid    = accept;
      bus.tlb_s_vppn     = win_vaddr[31:13];
      bus.tlb_s_va_bit12 = win_vaddr[12];
      bus.if_resp_valid  = (state_q == ST_RESP) && (id_q == REQ_IF);
      bus.ls_resp_valid  = (state_q == ST_RESP) && (id_q == REQ_LS);
      bus.resp_paddr     = paddr_q;
      bus.resp_ecode     = ecode_q;
   end

   // Next-state, starvation counter and latched request context.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      ofs_d    = ofs_q;
      id_d     = id_q;
      store_d  = store_q;
      paddr_d  = paddr_q;
      ecode_d  = ecode_q;

      if (bus.flush) begin
         state_d  = ST_IDLE;
         starve_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!bus.if_req_valid || grant_if) begin
                  starve_d = '0;
               end else if (starve_q != CNT_MAX) begin
                  starve_d = starve_q + 1'b1;
               end
               if (accept) begin
                  ofs_d   = win_vaddr[PAGE_OFS_W-1:0];
                  id_d    = grant_ls ? REQ_LS : REQ_IF;
                  store_d = grant_ls && bus.ls_is_store;
                  state_d = ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               ecode_d = chk_ecode;
               paddr_d = (chk_ecode == ECODE_NONE) ? make_paddr(bus.tlb_s_ppn, ofs_q) : '0;
               state_d = ST_RESP;
            end
            ST_RESP: begin
               if (resp_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and context registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
         ofs_q    <= '0;
         id_q     <= REQ_IF;
         store_q  <= 1'b0;
         paddr_q  <= '0;
         ecode_q  <= ECODE_NONE;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         ofs_q    <= ofs_d;
         id_q     <= id_d;
         store_q  <= store_d;
         paddr_q  <= paddr_d;
         ecode_q  <= ecode_d;
      end
   end

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// Directed bench for tlb_port_arbiter: reset, IF translation, permission
// codes, starvation, flush and response back-pressure.
module tb_tlb_port_arbiter;
   import mmu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   tlb_port_arbiter_if bus();

   tlb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      bit          ls;
      bit          st;
      logic [31:0] va;
      bit          f;
      bit          v;
      bit          d;
      logic [1:0]  plv;
      logic [1:0]  csr;
      ecode_t      ec;
      logic [31:0] pa;
   } pvec_t;

   // Advance to just after the next falling edge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.flush         = 1'b0;
      bus.if_req_valid  = 1'b0;
      bus.ls_req_valid  = 1'b0;
      bus.ls_is_store   = 1'b0;
      bus.if_resp_ready = 1'b0;
      bus.ls_resp_ready = 1'b0;
   endtask

   task automatic set_tlb(input bit f, input bit v, input bit d, input logic [1:0] plv,
                          input logic [19:0] ppn, input logic [1:0] csr);
      bus.tlb_s_found = f;
      bus.tlb_s_v     = v;
      bus.tlb_s_d     = d;
      bus.tlb_s_plv   = plv;
      bus.tlb_s_ppn   = ppn;
      bus.csr_plv     = csr;
   endtask

   // One complete transaction from IDLE back to IDLE; returns observations.
   task automatic xact(input bit ls, input logic [31:0] va, input bit st,
                       output bit rdy, output bit rv, output bit other_rv,
                       output logic [31:0] pa, output ecode_t ec);
      cyc();
      if (ls) begin
         bus.ls_req_valid = 1'b1; bus.ls_vaddr = va; bus.ls_is_store = st;
      end else begin
         bus.if_req_valid = 1'b1; bus.if_vaddr = va;
      end
      #1;
      rdy = ls ? bus.ls_req_ready : bus.if_req_ready;
      cyc();
      bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0; bus.ls_is_store = 1'b0;
      cyc();
      #1;
      rv       = ls ? bus.ls_resp_valid : bus.if_resp_valid;
      other_rv = ls ? bus.if_resp_valid : bus.ls_resp_valid;
      pa       = bus.resp_paddr;
      ec       = bus.resp_ecode;
      bus.if_resp_ready = 1'b1; bus.ls_resp_ready = 1'b1;
      cyc();
      bus.if_resp_ready = 1'b0; bus.ls_resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      quiet();
      set_tlb(1'b1, 1'b1, 1'b1, 2'd3, 20'h12345, 2'd3);
      bus.if_vaddr = 32'h0000_1000; bus.ls_vaddr = 32'h0000_2000;
      bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1;
      cyc(); cyc(); #1;
      n_total++; if (bus.if_req_ready !== 1'b0) $display("FAIL reset_if_ready: got %b exp 0", bus.if_req_ready); else n_pass++;
      n_total++; if (bus.ls_req_ready !== 1'b0) $display("FAIL reset_ls_ready: got %b exp 0", bus.ls_req_ready); else n_pass++;
      n_total++; if (bus.tlb_s_valid !== 1'b0) $display("FAIL reset_s_valid: got %b exp 0", bus.tlb_s_valid); else n_pass++;
      n_total++; if (bus.if_resp_valid !== 1'b0) $display("FAIL reset_if_rv: got %b exp 0", bus.if_resp_valid); else n_pass++;
      n_total++; if (bus.ls_resp_valid !== 1'b0) $display("FAIL reset_ls_rv: got %b exp 0", bus.ls_resp_valid); else n_pass++;
      n_total++; if (bus.resp_paddr !== 32'h0) $display("FAIL reset_paddr: got %h exp 0", bus.resp_paddr); else n_pass++;
      n_total++; if (bus.resp_ecode !== ECODE_NONE) $display("FAIL reset_ecode: got %0d exp 0", bus.resp_ecode); else n_pass++;
      quiet();
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_if_basic();
      quiet();
      set_tlb(1'b1, 1'b1, 1'b0, 2'd3, 20'hABCDE, 2'd3);
      cyc();
      bus.if_req_valid = 1'b1; bus.if_vaddr = 32'h1234_5678;
      #1;
      n_total++; if (bus.if_req_ready !== 1'b1) $display("FAIL ifb_ready: got %b exp 1", bus.if_req_ready); else n_pass++;
      n_total++; if (bus.ls_req_ready !== 1'b0) $display("FAIL ifb_ls_ready: got %b exp 0", bus.ls_req_ready); else n_pass++;
      n_total++; if (bus.tlb_s_valid !== 1'b1) $display("FAIL ifb_s_valid: got %b exp 1", bus.tlb_s_valid); else n_pass++;
      n_total++; if (bus.tlb_s_vppn !== 19'h091A2) $display("FAIL ifb_vppn: got %h exp 091a2", bus.tlb_s_vppn); else n_pass++;
      n_total++; if (bus.tlb_s_va_bit12 !== 1'b1) $display("FAIL ifb_bit12: got %b exp 1", bus.tlb_s_va_bit12); else n_pass++;
      cyc();
      bus.if_req_valid = 1'b0;
      #1;
      n_total++; if (bus.if_resp_valid !== 1'b0) $display("FAIL ifb_rv_n1: got %b exp 0", bus.if_resp_valid); else n_pass++;
      n_total++; if (bus.tlb_s_valid !== 1'b0) $display("FAIL ifb_s_valid_n1: got %b exp 0", bus.tlb_s_valid); else n_pass++;
      cyc(); #1;
      n_total++; if (bus.if_resp_valid !== 1'b1) $display("FAIL ifb_rv_n2: got %b exp 1", bus.if_resp_valid); else n_pass++;
      n_total++; if (bus.ls_resp_valid !== 1'b0) $display("FAIL ifb_ls_rv_n2: got %b exp 0", bus.ls_resp_valid); else n_pass++;
      n_total++; if (bus.resp_paddr !== 32'hABCD_E678) $display("FAIL ifb_paddr: got %h exp abcde678", bus.resp_paddr); else n_pass++;
      n_total++; if (bus.resp_ecode !== ECODE_NONE) $display("FAIL ifb_ecode: got %0d exp 0", bus.resp_ecode); else n_pass++;
      bus.if_resp_ready = 1'b1;
      cyc();
      bus.if_resp_ready = 1'b0;
      #1;
      n_total++; if (bus.if_resp_valid !== 1'b0) $display("FAIL ifb_rv_done: got %b exp 0", bus.if_resp_valid); else n_pass++;
   endtask

   task automatic test_perm();
      pvec_t       tbl [10];
      bit          rdy, rv, orv;
      logic [31:0] pa;
      ecode_t      ec;
      tbl[0] = '{1'b1, 1'b1, 32'h8000_1ABC, 1'b1, 1'b1, 1'b0, 2'd3, 2'd3, ECODE_PME,  32'h0};
      tbl[1] = '{1'b1, 1'b1, 32'h8000_1ABC, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3, ECODE_TLBR, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h0040_0FF0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, ECODE_PIL,  32'h0};
      tbl[3] = '{1'b1, 1'b1, 32'h0040_0FF0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, ECODE_PIS,  32'h0};
      tbl[4] = '{1'b0, 1'b0, 32'h0040_0FF0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, ECODE_PIF,  32'h0};
      tbl[5] = '{1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3, ECODE_PPI,  32'h0};
      tbl[6] = '{1'b1, 1'b1, 32'h8000_1ABC, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3, ECODE_NONE, 32'h5A5A_5ABC};
      tbl[7] = '{1'b1, 1'b1, 32'h8000_1ABC, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3, ECODE_PPI,  32'h0};
      tbl[8] = '{1'b1, 1'b0, 32'h0040_0FF0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, ECODE_NONE, 32'h5A5A_5FF0};
      tbl[9] = '{1'b0, 1'b0, 32'hFFFF_F004, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, ECODE_NONE, 32'h5A5A_5004};
      quiet();
      for (int i = 0; i < 10; i++) begin
         set_tlb(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].plv, 20'h5A5A5, tbl[i].csr);
         xact(tbl[i].ls, tbl[i].va, tbl[i].st, rdy, rv, orv, pa, ec);
         n_total++; if (rdy !== 1'b1) $display("FAIL perm%0d_ready: got %b exp 1", i, rdy); else n_pass++;
         n_total++; if (rv !== 1'b1) $display("FAIL perm%0d_rv: got %b exp 1", i, rv); else n_pass++;
         n_total++; if (orv !== 1'b0) $display("FAIL perm%0d_other_rv: got %b exp 0", i, orv); else n_pass++;
         n_total++; if (ec !== tbl[i].ec) $display("FAIL perm%0d_ecode: got %0d exp %0d", i, ec, tbl[i].ec); else n_pass++;
         n_total++; if (pa !== tbl[i].pa) $display("FAIL perm%0d_paddr: got %h exp %h", i, pa, tbl[i].pa); else n_pass++;
      end
   endtask

   task automatic test_starve();
      byte         seq  [6];
      int          at   [6];
      logic [18:0] vp   [6];
      int          ngr = 0;
      int          overlap = 0;
      byte         exp_seq [6];
      exp_seq = '{"L", "L", "L", "L", "I", "L"};
      quiet();
      set_tlb(1'b1, 1'b1, 1'b1, 2'd3, 20'h11111, 2'd3);
      bus.if_resp_ready = 1'b1; bus.ls_resp_ready = 1'b1;
      bus.if_vaddr = 32'h0000_2000; bus.ls_vaddr = 32'h0000_4000;
      cyc();
      bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1;
      for (int c = 0; c < 60 && ngr < 6; c++) begin
         #1;
         if (bus.if_req_ready && bus.ls_req_ready) overlap++;
         if (bus.ls_req_ready || bus.if_req_ready) begin
            seq[ngr] = bus.ls_req_ready ? "L" : "I";
            at[ngr]  = c;
            vp[ngr]  = bus.tlb_s_vppn;
            ngr++;
         end
         cyc();
      end
      bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
      cyc(); cyc(); cyc();
      quiet();
      n_total++; if (ngr !== 6) $display("FAIL starve_grants: got %0d exp 6 within budget", ngr); else n_pass++;
      n_total++; if (overlap !== 0) $display("FAIL starve_overlap: got %0d exp 0", overlap); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_total++; if (i >= ngr || seq[i] !== exp_seq[i]) $display("FAIL starve_seq%0d: got %s exp %s", i, (i < ngr) ? seq[i] : "-", exp_seq[i]); else n_pass++;
      end
      n_total++; if (ngr < 2 || (at[1] - at[0]) !== 3) $display("FAIL b2b_interval: got %0d exp 3", (ngr < 2) ? -1 : at[1] - at[0]); else n_pass++;
      n_total++; if (ngr < 1 || vp[0] !== 19'd2) $display("FAIL starve_ls_vppn: got %h exp 2", vp[0]); else n_pass++;
      n_total++; if (ngr < 5 || vp[4] !== 19'd1) $display("FAIL starve_if_vppn: got %h exp 1", vp[4]); else n_pass++;
   endtask

   task automatic test_flush();
      int if_seen = 0;
      int ls_seen = 0;
      int nls = 0;
      int nif = 0;
      quiet();
      set_tlb(1'b1, 1'b1, 1'b1, 2'd3, 20'h22222, 2'd3);
      // Flush while the search result is being evaluated.
      cyc();
      bus.if_req_valid = 1'b1; bus.if_vaddr = 32'h1234_5678;
      #1;
      n_total++; if (bus.if_req_ready !== 1'b1) $display("FAIL flush_a_accept: got %b exp 1", bus.if_req_ready); else n_pass++;
      cyc();
      bus.if_req_valid = 1'b0; bus.flush = 1'b1;
      bus.ls_req_valid = 1'b1; bus.ls_vaddr = 32'h0000_6000;
      #1;
      n_total++; if (bus.ls_req_ready !== 1'b0) $display("FAIL flush_a_ls_ready: got %b exp 0", bus.ls_req_ready); else n_pass++;
      n_total++; if (bus.tlb_s_valid !== 1'b0) $display("FAIL flush_a_s_valid: got %b exp 0", bus.tlb_s_valid); else n_pass++;
      cyc();
      bus.flush = 1'b0;
      #1;
      n_total++; if (bus.if_resp_valid !== 1'b0) $display("FAIL flush_a_dropped: got %b exp 0", bus.if_resp_valid); else n_pass++;
      n_total++; if (bus.ls_req_ready !== 1'b1) $display("FAIL flush_a_new_accept: got %b exp 1", bus.ls_req_ready); else n_pass++;
      cyc();
      bus.ls_req_valid = 1'b0; bus.ls_resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus.if_resp_valid) if_seen++;
         if (bus.ls_resp_valid) ls_seen++;
         cyc();
      end
      n_total++; if (if_seen !== 0) $display("FAIL flush_a_if_rv: got %0d exp 0", if_seen); else n_pass++;
      n_total++; if (ls_seen !== 1) $display("FAIL flush_a_ls_rv: got %0d exp 1", ls_seen); else n_pass++;
      quiet();
      // Flush coinciding with the response handshake.
      cyc();
      bus.ls_req_valid = 1'b1; bus.ls_vaddr = 32'h0000_7000;
      cyc();
      bus.ls_req_valid = 1'b0;
      cyc(); #1;
      n_total++; if (bus.ls_resp_valid !== 1'b1) $display("FAIL flush_b_rv: got %b exp 1", bus.ls_resp_valid); else n_pass++;
      bus.flush = 1'b1; bus.ls_resp_ready = 1'b1;
      cyc();
      bus.flush = 1'b0; bus.ls_resp_ready = 1'b0;
      #1;
      n_total++; if (bus.ls_resp_valid !== 1'b0) $display("FAIL flush_b_idle: got %b exp 0", bus.ls_resp_valid); else n_pass++;
      // Flush clears a saturated starvation counter.
      quiet();
      bus.if_resp_ready = 1'b1; bus.ls_resp_ready = 1'b1;
      bus.if_vaddr = 32'h0000_2000; bus.ls_vaddr = 32'h0000_4000;
      cyc();
      bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1;
      for (int c = 0; c < 40 && nls < 4; c++) begin
         #1;
         if (bus.ls_req_ready) nls++;
         if (bus.if_req_ready) nif++;
         cyc();
      end
      n_total++; if (nls !== 4 || nif !== 0) $display("FAIL flush_c_prefill: got ls=%0d if=%0d exp ls=4 if=0", nls, nif); else n_pass++;
      cyc(); cyc();
      bus.flush = 1'b1;
      #1;
      n_total++; if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0) $display("FAIL flush_c_ready: got if=%b ls=%b exp 0 0", bus.if_req_ready, bus.ls_req_ready); else n_pass++;
      cyc();
      bus.flush = 1'b0;
      #1;
      n_total++; if (bus.ls_req_ready !== 1'b1) $display("FAIL flush_c_ls_wins: got %b exp 1", bus.ls_req_ready); else n_pass++;
      n_total++; if (bus.if_req_ready !== 1'b0) $display("FAIL flush_c_if_loses: got %b exp 0", bus.if_req_ready); else n_pass++;
      cyc();
      bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
      cyc(); cyc();
      quiet();
   endtask

   task automatic test_back_pressure();
      quiet();
      set_tlb(1'b1, 1'b1, 1'b1, 2'd3, 20'h0F0F0, 2'd3);
      cyc();
      bus.ls_req_valid = 1'b1; bus.ls_vaddr = 32'h0000_3ABC; bus.ls_is_store = 1'b0;
      #1;
      n_total++; if (bus.ls_req_ready !== 1'b1) $display("FAIL bp_accept: got %b exp 1", bus.ls_req_ready); else n_pass++;
      cyc();
      bus.if_req_valid = 1'b1; bus.if_vaddr = 32'h0000_5000;
      bus.ls_vaddr = 32'h0000_8000;
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++; if (bus.ls_resp_valid !== 1'b1) $display("FAIL bp_rv_c%0d: got %b exp 1", i, bus.ls_resp_valid); else n_pass++;
         n_total++; if (bus.resp_paddr !== 32'h0F0F_0ABC) $display("FAIL bp_paddr_c%0d: got %h exp 0f0f0abc", i, bus.resp_paddr); else n_pass++;
         n_total++; if (bus.resp_ecode !== ECODE_NONE) $display("FAIL bp_ecode_c%0d: got %0d exp 0", i, bus.resp_ecode); else n_pass++;
         n_total++; if (bus.if_req_ready !== 1'b0) $display("FAIL bp_if_ready_c%0d: got %b exp 0", i, bus.if_req_ready); else n_pass++;
         n_total++; if (bus.ls_req_ready !== 1'b0) $display("FAIL bp_ls_ready_c%0d: got %b exp 0", i, bus.ls_req_ready); else n_pass++;
         cyc();
      end
      #1;
      n_total++; if (bus.ls_resp_valid !== 1'b1) $display("FAIL bp_rv_c5: got %b exp 1", bus.ls_resp_valid); else n_pass++;
      bus.ls_resp_ready = 1'b1;
      cyc();
      bus.ls_resp_ready = 1'b0;
      #1;
      n_total++; if (bus.ls_resp_valid !== 1'b0) $display("FAIL bp_rv_after: got %b exp 0", bus.ls_resp_valid); else n_pass++;
      n_total++; if (bus.ls_req_ready !== 1'b1) $display("FAIL bp_next_ls: got %b exp 1", bus.ls_req_ready); else n_pass++;
      n_total++; if (bus.if_req_ready !== 1'b0) $display("FAIL bp_next_if: got %b exp 0", bus.if_req_ready); else n_pass++;
      cyc();
      bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0; bus.ls_resp_ready = 1'b1;
      cyc(); cyc();
      quiet();
   endtask

   initial begin
      bus.if_vaddr = '0;
      bus.ls_vaddr = '0;
      test_reset();
      test_if_basic();
      test_perm();
      test_starve();
      test_flush();
      test_back_pressure();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule
